// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline hazard controller and any
// logic (e.g. forwarding) that reuses the load-use comparator.
//   hz_state_e : controller state (RUN, LU_STALL)
//   REG_X0     : hard-wired zero register index
//   BUB_W      : width of the load-use bubble counter
// -----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } hz_state_e;

    localparam logic [4:0] REG_X0 = 5'd0;
    localparam int         BUB_W  = 3;

endpackage

// File: rtl/hazard_ctrl_load_use_cmp.sv
// -----------------------------------------------------------------------------
// load_use_cmp
// Combinational load-use hazard detector: flags an ID instruction that reads
// the destination of a load still sitting in ID/EX.
//   i_id_rs1, i_id_rs2           : source register fields in ID
//   i_id_rs1_used, i_id_rs2_used : ID instruction actually reads that source
//   i_idex_memread, i_idex_rd    : ID/EX holds a load targeting i_idex_rd
//   o_lu_hit                     : load-use hazard present
// -----------------------------------------------------------------------------
module load_use_cmp
    import hazard_pkg::*;
(
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_rs1_used,
    input  logic       i_id_rs2_used,
    input  logic       i_idex_memread,
    input  logic [4:0] i_idex_rd,
    output logic       o_lu_hit
);

    logic w_rs1_match;
    logic w_rs2_match;

    assign w_rs1_match = i_id_rs1_used && (i_id_rs1 == i_idex_rd);
    assign w_rs2_match = i_id_rs2_used && (i_id_rs2 == i_idex_rd);

    // x0 is never written, so a "load" into it cannot create a dependency.
    assign o_lu_hit = i_idex_memread && (i_idex_rd != REG_X0) &&
                      (w_rs1_match || w_rs2_match);

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Mealy hazard controller driving freeze / bubble / flush controls into the
// front of a five-stage pipeline.
// Parameters:
//   LOAD_LAT : bubbles inserted on a load-use hazard (1..7)
//   CNT_W    : performance counter width (HAZARD_PERF_EN builds only)
// Ports:
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_id_*                 : source fields / use flags of the ID instruction
//   i_idex_memread/_rd     : load currently in ID/EX and its destination
//   i_ex_branch_taken      : taken branch/jump resolved in EX this cycle
//   i_dmem_wait            : data memory stall, freezes the whole pipeline
//   o_pc_stall             : PC holds
//   o_if_id_stall/_flush   : IF/ID holds / loads a NOP
//   o_id_ex_hold/_clear    : ID/EX holds / loads a bubble
//   o_ex_mem_hold          : EX/MEM and MEM/WB hold
//   o_stall_cnt/_flush_cnt : cycle counters, present only when the macro
//                            HAZARD_PERF_EN is defined
// Outputs are combinational from state and inputs (zero-cycle latency).
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_rs1_used,
    input  logic       i_id_rs2_used,
    input  logic       i_idex_memread,
    input  logic [4:0] i_idex_rd,
    input  logic       i_ex_branch_taken,
    input  logic       i_dmem_wait,
    output logic       o_pc_stall,
    output logic       o_if_id_stall,
    output logic       o_if_id_flush,
    output logic       o_id_ex_hold,
    output logic       o_id_ex_clear,
    output logic       o_ex_mem_hold
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
`endif
);

    generate
        if (LOAD_LAT < 1 || LOAD_LAT > 7 || CNT_W < 1) begin : g_bad_param
            $error("hazard_ctrl: LOAD_LAT must be 1..7 and CNT_W >= 1");
        end
    endgenerate

    // Bubbles still owed after the detection cycle.
    localparam logic [BUB_W-1:0] LAT_M1 = BUB_W'(LOAD_LAT - 1);

    hz_state_e        r_state, w_state_d;
    logic [BUB_W-1:0] r_bub_cnt, w_bub_cnt_d;
    logic             w_lu_hit;

    load_use_cmp u_lu_cmp (
        .i_id_rs1       (i_id_rs1),
        .i_id_rs2       (i_id_rs2),
        .i_id_rs1_used  (i_id_rs1_used),
        .i_id_rs2_used  (i_id_rs2_used),
        .i_idex_memread (i_idex_memread),
        .i_idex_rd      (i_idex_rd),
        .o_lu_hit       (w_lu_hit)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= RUN;
            r_bub_cnt <= '0;
        end else begin
            r_state   <= w_state_d;
            r_bub_cnt <= w_bub_cnt_d;
        end
    end

    // Priority: rst > dmem_wait > branch > LU_STALL hold > new load-use hit.
    always_comb begin
        o_pc_stall    = 1'b0;
        o_if_id_stall = 1'b0;
        o_if_id_flush = 1'b0;
        o_id_ex_hold  = 1'b0;
        o_id_ex_clear = 1'b0;
        o_ex_mem_hold = 1'b0;
        w_state_d     = r_state;
        w_bub_cnt_d   = r_bub_cnt;

        if (i_rst) begin
            // all outputs low; state cleared by the register process
        end else if (i_dmem_wait) begin
            // Full freeze: state and bubble count stay put, so a pending
            // load-use stall resumes where it left off.
            o_pc_stall    = 1'b1;
            o_if_id_stall = 1'b1;
            o_id_ex_hold  = 1'b1;
            o_ex_mem_hold = 1'b1;
        end else if (i_ex_branch_taken) begin
            // PC loads the target; both younger slots are squashed, which
            // also discards any stalled dependent instruction.
            o_if_id_flush = 1'b1;
            o_id_ex_clear = 1'b1;
            w_state_d     = RUN;
            w_bub_cnt_d   = '0;
        end else if (r_state == LU_STALL) begin
            o_pc_stall    = 1'b1;
            o_if_id_stall = 1'b1;
            o_id_ex_clear = 1'b1;
            w_bub_cnt_d   = r_bub_cnt - BUB_W'(1);
            if (r_bub_cnt == BUB_W'(1)) begin
                w_state_d = RUN;
            end
        end else if (w_lu_hit) begin
            o_pc_stall    = 1'b1;
            o_if_id_stall = 1'b1;
            o_id_ex_clear = 1'b1;
            if (LOAD_LAT > 1) begin
                w_state_d   = LU_STALL;
                w_bub_cnt_d = LAT_M1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (o_pc_stall)    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (o_if_id_flush) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
`endif

endmodule
